// File: rtl/psm_pkg.sv
// psm_pkg: shared thresholds, mode encodings and saturating step helper
package psm_pkg;
   localparam int V_LOW_DEF = 'hE1A;
   localparam int V_HIGH_DEF = 'hE3C;
   localparam logic MODE_SKIP = 1'b0;
   localparam logic MODE_ADAPT = 1'b1;
   function automatic int unsigned sat_step(input int unsigned val, input int unsigned step,
                                            input int unsigned lo, input int unsigned hi, input logic up);
      return up ? ((val + step > hi) ? hi : val + step) : ((val < lo + step) ? lo : val - step);
   endfunction
endpackage

// File: rtl/psm_hyst.sv
// psm_hyst: hysteresis comparator on voltage samples plus adaptive duty stepper
module psm_hyst import psm_pkg::*; #(
   parameter int RESOLUTION = 8,
   parameter int SAMPLE_W = 12,
   parameter int DUTY_MIN = 16,
   parameter int DUTY_MAX = 240,
   parameter int DUTY_STEP = 8,
   parameter int V_LOW = V_LOW_DEF,
   parameter int V_HIGH = V_HIGH_DEF
) (
   input logic clk,
   input logic reset_n,
   input logic sample_valid,
   input logic [SAMPLE_W-1:0] sample_data,
   output logic voltage_low,
   output logic [RESOLUTION:0] duty_reg
);
   localparam logic [SAMPLE_W-1:0] VL = SAMPLE_W'(V_LOW);
   localparam logic [SAMPLE_W-1:0] VH = SAMPLE_W'(V_HIGH);
   logic below, above;
   assign below = sample_data < VL;
   assign above = sample_data > VH;
   // both the low flag and the duty register move only on a valid sample
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         voltage_low <= 1'b0;
         duty_reg <= (RESOLUTION+1)'(DUTY_MIN);
      end else if (sample_valid) begin
         voltage_low <= below ? 1'b1 : above ? 1'b0 : voltage_low;
         duty_reg <= (below || above)
            ? (RESOLUTION+1)'(sat_step(32'(duty_reg), DUTY_STEP, DUTY_MIN, DUTY_MAX, below))
            : duty_reg;
      end
endmodule

// File: rtl/psm_adaptive.sv
// psm_adaptive: pulse-skipping / adaptive-duty PWM modulator with skip statistics
module psm_adaptive import psm_pkg::*; #(
   parameter int RESOLUTION = 8,
   parameter int SAMPLE_W = 12,
   parameter int DUTY = 128,
   parameter int DUTY_MIN = 16,
   parameter int DUTY_MAX = 240,
   parameter int DUTY_STEP = 8,
   parameter int V_LOW = V_LOW_DEF,
   parameter int V_HIGH = V_HIGH_DEF,
   parameter int CNT_W = 16
) (
   input logic clk,
   input logic reset_n,
   input logic sample_valid,
   input logic [SAMPLE_W-1:0] sample_data,
   input logic mode,
   input logic skip_clr,
   output logic psm_out,
   output logic voltage_low,
   output logic [RESOLUTION-1:0] duty_now,
   output logic period_start,
   output logic [CNT_W-1:0] skip_count
);
   localparam int TOP = (1 << RESOLUTION) - 1;
   localparam logic [RESOLUTION-1:0] DUTY_FIX = RESOLUTION'(DUTY > TOP ? TOP : DUTY);
   logic [RESOLUTION-1:0] cnt, k, duty_adapt;
   logic [RESOLUTION:0] duty_reg;
   logic start, en, mode_q;
   assign start = cnt == '0;
   // the output stage lags the counter by one clock, so it compares the previous count
   assign k = cnt - 1'b1;
   assign duty_adapt = duty_reg[RESOLUTION] ? '1 : duty_reg[RESOLUTION-1:0];

   psm_hyst #(
      .RESOLUTION(RESOLUTION), .SAMPLE_W(SAMPLE_W), .DUTY_MIN(DUTY_MIN),
      .DUTY_MAX(DUTY_MAX), .DUTY_STEP(DUTY_STEP), .V_LOW(V_LOW), .V_HIGH(V_HIGH)
   ) u_hyst (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .voltage_low(voltage_low), .duty_reg(duty_reg)
   );

   // free-running period counter
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= cnt + 1'b1;

   // period-start latch: mode, duty and gate enable are frozen for a whole period
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         mode_q <= MODE_SKIP;
         en <= 1'b0;
         duty_now <= '0;
         period_start <= 1'b0;
      end else begin
         period_start <= start;
         if (start) begin
            mode_q <= mode;
            duty_now <= (mode == MODE_ADAPT) ? duty_adapt : DUTY_FIX;
            en <= (mode == MODE_ADAPT) | voltage_low;
         end
      end

   // registered gate drive
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) psm_out <= 1'b0;
      else psm_out <= en & (k < duty_now);

   // saturating count of skipped periods, clear wins over increment
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) skip_count <= '0;
      else if (skip_clr) skip_count <= '0;
      else if (period_start && mode_q == MODE_SKIP && !en && !(&skip_count)) skip_count <= skip_count + 1'b1;
endmodule

// File: tb/tb_psm_adaptive.sv
// tb_psm_adaptive: directed self-checking bench for psm_adaptive
module tb_psm_adaptive;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic sample_valid = 1'b0;
   logic [11:0] sample_data = '0;
   logic mode = 1'b0;
   logic skip_clr = 1'b0;
   logic psm_out, voltage_low, period_start;
   logic [7:0] duty_now;
   logic [15:0] skip_count;
   logic psm_out2, voltage_low2, period_start2;
   logic [1:0] duty_now2;
   logic [3:0] skip_count2;
   int n_chk = 0;
   int n_err = 0;
   int h;

   always #5 clk = ~clk;

   psm_adaptive dut (
      .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_data(sample_data),
      .mode(mode), .skip_clr(skip_clr), .psm_out(psm_out), .voltage_low(voltage_low),
      .duty_now(duty_now), .period_start(period_start), .skip_count(skip_count)
   );

   // tiny instance: 4-clock period and 4-bit skip counter to reach saturation quickly
   psm_adaptive #(
      .RESOLUTION(2), .DUTY(2), .DUTY_MIN(1), .DUTY_MAX(3), .DUTY_STEP(1), .CNT_W(4)
   ) dut2 (
      .clk(clk), .reset_n(reset_n), .sample_valid(1'b0), .sample_data(12'h000),
      .mode(1'b0), .skip_clr(1'b0), .psm_out(psm_out2), .voltage_low(voltage_low2),
      .duty_now(duty_now2), .period_start(period_start2), .skip_count(skip_count2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic wait_start();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_start && n < 400);
      if (!period_start) chk("start_timeout", 0, 1);
   endtask

   task automatic measure(output int hi);
      hi = 0;
      repeat (255) begin
         @(negedge clk);
         hi += int'(psm_out);
      end
   endtask

   task automatic drive_sample(input logic [11:0] d);
      sample_data = d;
      sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   initial begin
      #22;
      chk("rst_psm", psm_out, 0);
      chk("rst_vlow", voltage_low, 0);
      chk("rst_duty", duty_now, 0);
      chk("rst_pstart", period_start, 0);
      chk("rst_skip", skip_count, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int p = 0; p < 3; p++) begin
         wait_start();
         measure(h);
         chk("skip_duty", duty_now, 128);
         chk("skip_idle_hi", h, 0);
         chk("skip_cnt", skip_count, p + 1);
      end
      wait_start();
      drive_sample(12'hE00);
      chk("vlow_set", voltage_low, 1);
      wait_start();
      measure(h);
      chk("skip_on_hi", h, 128);
      chk("skip_on_cnt", skip_count, 4);
      wait_start();
      drive_sample(12'hE2A);
      chk("vlow_band", voltage_low, 1);
      drive_sample(12'hE50);
      chk("vlow_clr", voltage_low, 0);
      wait_start();
      measure(h);
      chk("skip_off_hi", h, 0);
      chk("skip_off_cnt", skip_count, 5);
      mode = 1'b1;
      wait_start();
      chk("adapt_duty0", duty_now, 16);
      drive_sample(12'hD00);
      wait_start();
      chk("adapt_duty1", duty_now, 24);
      repeat (39) drive_sample(12'hD00);
      wait_start();
      chk("adapt_max", duty_now, 240);
      measure(h);
      chk("adapt_max_hi", h, 240);
      drive_sample(12'hF00);
      chk("same_cyc_pstart", period_start, 1);
      chk("same_cyc_old", duty_now, 240);
      wait_start();
      chk("same_cyc_new", duty_now, 232);
      repeat (40) drive_sample(12'hF00);
      wait_start();
      chk("adapt_min", duty_now, 16);
      measure(h);
      chk("adapt_min_hi", h, 16);
      mode = 1'b0;
      wait_start();
      chk("clr_before", skip_count, 5);
      skip_clr = 1'b1;
      @(negedge clk);
      skip_clr = 1'b0;
      chk("clr_prio", skip_count, 0);
      wait_start();
      @(negedge clk);
      chk("clr_then_inc", skip_count, 1);
      drive_sample(12'hE00);
      wait_start();
      repeat (51) @(negedge clk);
      chk("pre_rst_hi", psm_out, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_psm", psm_out, 0);
      chk("async_vlow", voltage_low, 0);
      chk("async_duty", duty_now, 0);
      chk("async_skip", skip_count, 0);
      @(negedge clk);
      mode = 1'b1;
      reset_n = 1'b1;
      @(negedge clk);
      chk("restart_pstart", period_start, 1);
      chk("restart_psm", psm_out, 0);
      chk("restart_duty", duty_now, 16);
      chk("restart_vlow", voltage_low, 0);
      @(negedge clk);
      chk("restart_psm_hi", psm_out, 1);
      chk("small_skip", skip_count2, 1);
      repeat (80) @(negedge clk);
      chk("small_sat", skip_count2, 15);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/psm_adaptive.md
# psm_adaptive

Second-generation pulse-skipping modulator for the load-voltage control loop. It takes 12-bit load-voltage samples from the ADC front end through a valid strobe and applies hysteresis against two programmable thresholds. It then either gates a fixed-duty PWM train on whole-period boundaries (skip mode) or steps the PWM duty up and down within clamped limits (adaptive mode). It sits between the XADC sample path and the power-stage gate driver, and reports skipped-period statistics for energy-saving characterisation.

## Interface
- `RESOLUTION`, 8: PWM counter width; period = 2^RESOLUTION clocks.
- `SAMPLE_W`, 12: voltage sample width (ADC code, upper bits of the XADC result).
- `DUTY`, 128: duty used in skip mode; high time in clocks.
- `DUTY_MIN`, 16: adaptive-mode lower clamp.
- `DUTY_MAX`, 240: adaptive-mode upper clamp.
- `DUTY_STEP`, 8: adaptive-mode increment/decrement per qualifying sample.
- `V_LOW`, 12'hE1A: below this, voltage is low.
- `V_HIGH`, 12'hE3C: above this, voltage is recovered; requires `V_LOW < V_HIGH`.
- `CNT_W`, 16: skip-counter width.

- `clk`, in, 1: single system clock. All logic is on its rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `sample_valid`, in, 1: one-cycle strobe; `sample_data` is valid.
- `sample_data`, in, SAMPLE_W: load-voltage code.
- `mode`, in, 1: 0 = skip mode, 1 = adaptive mode. Sampled only at period start.
- `skip_clr`, in, 1: synchronous clear of `skip_count`.
- `psm_out`, out, 1: registered gate-drive output.
- `voltage_low`, out, 1: hysteresis comparator state.
- `duty_now`, out, RESOLUTION: duty latched for the current period.
- `period_start`, out, 1: one-cycle pulse in the first clock of each period.
- `skip_count`, out, CNT_W: number of skipped periods; saturates at all-ones.

## Operation
- Reset values: `psm_out`=0, `voltage_low`=0, `duty_now`=0, `period_start`=0, `skip_count`=0. The internal counter, enable latch and mode latch are 0. The adaptive duty register resets to `DUTY_MIN`.
- Hysteresis, evaluated only on cycles with `sample_valid`=1:
  - `sample_data < V_LOW` sets `voltage_low`=1.
  - `sample_data > V_HIGH` clears `voltage_low`=0.
  - Otherwise `voltage_low` holds.
  - All comparisons are unsigned.
- Adaptive duty register, updated on `sample_valid` regardless of mode:
  - Below `V_LOW`: add `DUTY_STEP`, saturating at `DUTY_MAX`.
  - Above `V_HIGH`: subtract `DUTY_STEP`, saturating at `DUTY_MIN`.
  - Otherwise: hold.
  - Compute in RESOLUTION+1 bits so the clamp is applied before any wrap.
- Period counter: free-running, counts 0 to 2^RESOLUTION-1 and wraps. Period start is the cycle in which the counter equals 0.
- Period-start latch. When the counter equals 0:
  - Latch `mode`.
  - In skip mode: latch `duty_now`=`DUTY` and enable=`voltage_low`.
  - In adaptive mode: latch `duty_now`=duty register and enable=1.
  - Gating never changes mid-period, so no runt pulses are produced.
- Output: `psm_out` = enable & (counter < `duty_now`), registered.
  - `duty_now`=0 gives a constant 0.
  - Duty values ≥ 2^RESOLUTION are clamped to 2^RESOLUTION-1 when the period starts.
- Skip counter:
  - Increments at each period start where skip mode is latched with enable=0.
  - Saturates at all-ones.
  - `skip_clr` has priority over increment in the same cycle.

## Timing
- A `sample_valid` in cycle N updates `voltage_low` and the duty register in cycle N+1.
- A sample arriving in the same cycle as the period-start latch is not seen by that period; the latch uses the pre-update values.
- The latch acts in the cycle the counter equals 0. `duty_now` and `period_start` are visible from the next cycle. `psm_out` reflects counter value k one cycle later.
- First `psm_out` high after reset is no earlier than clock 2^RESOLUTION+1 of skip mode with a low sample, or clock 2 of adaptive mode.
- Mid-period reset: all outputs go to their reset values immediately (asynchronous), and the counter restarts at 0 on release.
- `mode` toggling mid-period has no effect until the next period start.

## Structure
- Shared package `psm_pkg`:
  - Threshold defaults `V_LOW`/`V_HIGH`.
  - Mode encoding constants `MODE_SKIP`/`MODE_ADAPT`.
  - Saturating add/subtract function.
- One sub-module `psm_hyst`: sample comparator plus duty stepper, taking `sample_valid`/`sample_data` and producing `voltage_low` and the duty register.
- The top module holds the period counter, period-start latch, output register and skip counter.

## Test plan
- Reset, skip mode, no samples → `psm_out`=0 for 3 periods; `skip_count`=3 after the third period start; `duty_now`=128.
- Skip mode, sample 12'hE00 → `voltage_low`=1 next cycle; the following period gives `psm_out` high for exactly 128 clocks of the 256-clock period. Sample 12'hE2A (inside the hysteresis band) → stays 1. Sample 12'hE50 → the next period is fully low and `skip_count` increments.
- Adaptive mode, 40 consecutive samples of 12'hD00 → duty rises 16, 24, … and clamps at 240; `psm_out` high for 240 clocks per period. Then 40 samples of 12'hF00 → duty falls and clamps at 16.
- Sample strobed in the same cycle the counter equals 0 → that period uses the old duty; the next period uses the new duty.
- `skip_clr` asserted in the same cycle as a skip increment → `skip_count`=0. Force 65535 skips → `skip_count` holds at 16'hFFFF.
- Assert `reset_n`=0 mid-pulse at count 50 → `psm_out` drops asynchronously. On release the counter restarts, the duty register is 16 and `voltage_low`=0.
